seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexes a DIGITS-digit 4-bit code message onto one shared BCD-to-7-segment decoder.
//  Drives decoder code/enable and active-low common-anode digit strobes.
//  Inserts a blanking dead-time at each digit change to suppress ghosting.
//  Takes new messages from the vending FSM via a ready/load handshake, applied only at frame boundaries.
// PARAMETERS
//  DIGITS     4      number of multiplexed digits (>=1)
//  SCAN_DIV   50000  clock cycles per digit slot (>=2)
//  BLANK_CYC  16     leading cycles of each slot with all strobes off (1 <= BLANK_CYC < SCAN_DIV)
// PORTS
//  clk        in   1         single system clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  disp_on    in   1         1 = display enabled; 0 = strobes forced off, scan keeps running
//  msg_load   in   1         load request; accepted when msg_load & msg_ready
//  msg_data   in   4*DIGITS  digit codes; digit i = msg_data[4*i+3:4*i]; digit 0 is rightmost
//  msg_ready  out  1         1 = shadow register free, load may be accepted
//  dec_x      out  4         code to shared decoder X input
//  dec_p      out  1         decoder enable P
//  an_n       out  DIGITS    active-low digit strobes, one-hot-low while driving
//  frame_tick out  1         one-cycle pulse on the last cycle of digit DIGITS-1's slot
// BEHAVIOUR
//  Reset (async, all outputs registered): an_n all 1, dec_x=0, dec_p=0, msg_ready=1, frame_tick=0;
//   slot counter cnt=0, digit index idx=0, active message = 0, shadow = 0, pending = 0.
//  Slot counter: cnt runs 0..SCAN_DIV-1 then wraps to 0. At wrap, idx increments modulo DIGITS.
//  Per-slot states:
//   BLANK  (cnt < BLANK_CYC): an_n all 1, dec_p=0; dec_x loaded with active[idx] on entry (cnt==0).
//   DRIVE  (cnt >= BLANK_CYC): an_n[idx]=0, others 1; dec_p=1; dec_x held stable.
//   A disp_on=0 cycle forces BLANK outputs in DRIVE; cnt/idx/handshake unaffected.
//   Re-asserting disp_on mid-slot resumes DRIVE the following cycle.
//  Outputs are registered: each state decision appears on the pins one cycle later.
//   On pins, each slot therefore shows exactly BLANK_CYC blank cycles and SCAN_DIV-BLANK_CYC drive cycles.
//   dec_x never changes while any strobe is low.
//  Handshake:
//   Load accepted on msg_load & msg_ready: shadow<=msg_data, pending<=1, msg_ready<=0 next cycle.
//   msg_load while msg_ready=0 is ignored; shadow is not overwritten.
//  Commit:
//   On the frame_tick cycle with pending=1: active<=shadow, pending<=0, msg_ready<=1 next cycle.
//   The new message is shown from digit 0 of the next frame.
//  Simultaneous events:
//   A load accepted on the frame_tick cycle itself (pending was 0) is not committed that cycle.
//   It waits for the following frame boundary.
//   No frame ever displays a mix of old and new digits.
//  Codes are passed through unchecked; decoder interprets 0-9 and message-letter codes.
//  DIGITS=1: idx stays 0, frame_tick pulses every SCAN_DIV cycles.
//  Reset mid-slot or mid-handshake: immediate return to reset values.
//   Any pending message is discarded; the first frame after reset shows the all-zero message.
// STRUCTURE
//  Package seg_scan_pkg: state enum {BLANK, DRIVE}, CODE_W=4 localparam.
//  Package seg_scan_pkg also holds a width function clog2 for cnt/idx sizing.
//  Sub-module scan_prescaler:
//   Holds cnt and idx counters.
//   Emits slot_start, in_blank and frame_end strobes.
//   Parameters: SCAN_DIV, BLANK_CYC, DIGITS.
//  Top level holds shadow/active registers, handshake FSM and output registers.
//  The shared decoder is instantiated by the parent, not inside this block.
// TESTING  (bench params DIGITS=4, SCAN_DIV=8, BLANK_CYC=2; frame = 32 cycles)
//  1 Reset: assert rst_n=0 mid-run -> same cycle an_n=4'b1111, dec_p=0, dec_x=0, msg_ready=1,
//    frame_tick=0; after release first frame shows 0 on all digits.
//  2 Load 16'h1234 with msg_ready=1 -> msg_ready=0 next cycle; next frame_tick commits, msg_ready=1;
//    following frame: slot0 dec_x=4, an_n=1110; slot1 dec_x=3, an_n=1101; slot2 2; slot3 1.
//  3 Dead time: every slot -> 2 cycles an_n=1111 & dec_p=0, then 6 cycles one strobe low & dec_p=1;
//    dec_x changes only while an_n=1111.
//  4 While msg_ready=0, pulse msg_load with 16'hFFFF -> ignored; displayed and committed value stays 16'h1234.
//  5 Load 16'h5678 on the frame_tick cycle -> frame after shows old message; 16'h5678 appears one frame later.
//  6 disp_on=0 for 40 cycles -> an_n=1111, dec_p=0 throughout; frame_tick still every 32 cycles;
//    disp_on=1 resumes scan at the correct idx.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types, widths and helpers for the multiplexed seven-segment scanner.
package seg_scan_pkg;

  // Width of one digit code on the shared decoder bus.
  localparam int unsigned CODE_W = 4;

  // Per-slot output decision: strobes off, or one strobe driving.
  typedef enum logic {
    StBlank,
    StDrive
  } slot_state_e;

  // Message handshake: shadow register free, or holding a message awaiting commit.
  typedef enum logic {
    HsIdle,
    HsPending
  } hs_state_e;

  // Bits needed to count 0..value-1; never less than 1 so single-value counters stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Message handshake between the vending FSM (master) and the display scanner (slave).
interface seg_scan_ctrl_if
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);

  logic                       msg_load;
  logic [CODE_W*DIGITS-1:0]   msg_data;
  logic                       msg_ready;

  modport master (
    output msg_load,
    output msg_data,
    input  msg_ready
  );

  modport slave (
    input  msg_load,
    input  msg_data,
    output msg_ready
  );

endinterface

// File: rtl/scan_prescaler.sv
// Slot counter and digit index for the display scan, plus slot/frame timing strobes.
module scan_prescaler
  import seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned DIGITS    = 4,
  localparam int unsigned IDX_W    = clog2(DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             slot_start,
  output logic             in_blank,
  output logic             frame_end,
  output logic [IDX_W-1:0] idx
);

  localparam int unsigned      CNT_W     = clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_end;

  // Next-state for the slot counter and digit index; index advances only at slot wrap.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Strobes are decoded from the current count; the top registers everything it drives.
  always_comb begin
    slot_start = (cnt_q == '0);
    in_blank   = (cnt_q < CNT_BLANK);
    frame_end  = slot_end && (idx_q == IDX_LAST);
    idx        = idx_q;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexes a multi-digit code message onto one shared 7-segment decoder with
// per-slot blanking dead-time and frame-aligned message updates.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_on,
  seg_scan_ctrl_if.slave    msg_if,
  output logic [CODE_W-1:0] dec_x,
  output logic              dec_p,
  output logic [DIGITS-1:0] an_n,
  output logic              frame_tick
);

  localparam int unsigned IDX_W = clog2(DIGITS);
  localparam int unsigned MSG_W = CODE_W * DIGITS;

  logic             slot_start;
  logic             in_blank;
  logic             frame_end;
  logic [IDX_W-1:0] idx;

  scan_prescaler #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .DIGITS    (DIGITS)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_start (slot_start),
    .in_blank   (in_blank),
    .frame_end  (frame_end),
    .idx        (idx)
  );

  logic [MSG_W-1:0] shadow_q;
  logic [MSG_W-1:0] active_q;
  hs_state_e        hs_q;
  logic             msg_ready_q;

  // Handshake FSM: accept into shadow when free; commit to active only on the last cycle of a
  // frame so the next frame starts at digit 0 with the whole new message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      active_q    <= '0;
      hs_q        <= HsIdle;
      msg_ready_q <= 1'b1;
    end else begin
      unique case (hs_q)
        HsIdle: begin
          if (msg_if.msg_load && msg_ready_q) begin
            shadow_q    <= msg_if.msg_data;
            hs_q        <= HsPending;
            msg_ready_q <= 1'b0;
          end
        end
        HsPending: begin
          // A load taken on a frame_end cycle arrives here one cycle later, so it waits a frame.
          if (frame_end) begin
            active_q    <= shadow_q;
            hs_q        <= HsIdle;
            msg_ready_q <= 1'b1;
          end
        end
        default: hs_q <= HsIdle;
      endcase
    end
  end

  assign msg_if.msg_ready = msg_ready_q;

  slot_state_e       slot_st_d;
  logic [DIGITS-1:0] an_n_d;
  logic [CODE_W-1:0] active_code;

  // Slot decision for this cycle; disp_on=0 forces blank without touching the scan.
  always_comb begin
    slot_st_d = (in_blank || !disp_on) ? StBlank : StDrive;
    for (int i = 0; i < DIGITS; i++) begin
      an_n_d[i] = !((slot_st_d == StDrive) && (idx == IDX_W'(i)));
    end
    active_code = active_q[int'(idx) * CODE_W +: CODE_W];
  end

  logic [DIGITS-1:0] an_n_q;
  logic              dec_p_q;
  logic [CODE_W-1:0] dec_x_q;
  logic              frame_tick_q;

  // Output registers; dec_x is only reloaded at slot start, which is always blank on the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n_q       <= '1;
      dec_p_q      <= 1'b0;
      dec_x_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      an_n_q       <= an_n_d;
      dec_p_q      <= (slot_st_d == StDrive);
      frame_tick_q <= frame_end;
      if (slot_start) begin
        dec_x_q <= active_code;
      end
    end
  end

  assign an_n       = an_n_q;
  assign dec_p      = dec_p_q;
  assign dec_x      = dec_x_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-indexed reference model pushes the expected pin
// values for every cycle; a monitor pops and compares them.
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned FRAME     = DIGITS * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       disp_on = 1'b0;
  logic [3:0] dec_x;
  logic       dec_p;
  logic [3:0] an_n;
  logic       frame_tick;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) msg_if ();

  seg_scan_ctrl #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_on    (disp_on),
    .msg_if     (msg_if),
    .dec_x      (dec_x),
    .dec_p      (dec_p),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an_n;
    logic       dec_p;
    logic [3:0] dec_x;
    logic       ft;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: k counts cycles since reset release; message shown per whole frame.
  int unsigned k;
  logic [15:0] shown_msg;
  logic [15:0] pend_msg;
  bit          pend;

  function automatic void check(input string name, input logic [15:0] act,
                                input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t (k=%0d)", name, act, req, $time, k);
    end
  endfunction

  // Drive one cycle of inputs and predict the pins for the following cycle.
  task automatic step(input bit load, input logic [15:0] data, input bit disp);
    exp_t        e;
    int unsigned cnt;
    int unsigned idx;
    logic [3:0]  one;
    msg_if.msg_load = load;
    msg_if.msg_data = data;
    disp_on         = disp;
    cnt = k % SCAN_DIV;
    idx = (k / SCAN_DIV) % DIGITS;
    one = 4'b0001;
    if (cnt < BLANK_CYC || !disp) begin
      e.an_n  = 4'hF;
      e.dec_p = 1'b0;
    end else begin
      e.an_n  = ~(one << idx);
      e.dec_p = 1'b1;
    end
    e.dec_x = 4'((shown_msg >> (4 * idx)) & 16'hF);
    e.ft    = ((k % FRAME) == FRAME - 1);
    if (e.ft && pend) begin
      shown_msg = pend_msg;
      pend      = 1'b0;
    end else if (load && !pend) begin
      pend_msg = data;
      pend     = 1'b1;
    end
    e.rdy = !pend;
    exp_q.push_back(e);
    k++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit disp);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, disp);
  endtask

  // Async reset: outputs must take reset values immediately, before any clock edge.
  task automatic do_reset();
    rst_n           = 1'b0;
    msg_if.msg_load = 1'b0;
    #1;
    check("reset an_n", 16'(an_n), 16'hF);
    check("reset dec_p", 16'(dec_p), 16'h0);
    check("reset dec_x", 16'(dec_x), 16'h0);
    check("reset msg_ready", 16'(msg_if.msg_ready), 16'h1);
    check("reset frame_tick", 16'(frame_tick), 16'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    k         = 0;
    shown_msg = 16'h0;
    pend_msg  = 16'h0;
    pend      = 1'b0;
  endtask

  // Monitor: compare pins against the scoreboard shortly after each active edge.
  initial begin : monitor
    exp_t       e;
    logic [3:0] prev_x;
    prev_x = 4'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_x = 4'h0;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an_n", 16'(an_n), 16'(e.an_n));
        check("dec_p", 16'(dec_p), 16'(e.dec_p));
        check("dec_x", 16'(dec_x), 16'(e.dec_x));
        check("frame_tick", 16'(frame_tick), 16'(e.ft));
        check("msg_ready", 16'(msg_if.msg_ready), 16'(e.rdy));
        check("dec_x stable while strobing", 16'((an_n == 4'hF) || (dec_x == prev_x)), 16'h1);
        prev_x = dec_x;
      end
    end
  end

  initial begin : stimulus
    msg_if.msg_load = 1'b0;
    msg_if.msg_data = 16'h0;
    @(negedge clk);
    do_reset();

    // Power-up frame shows the all-zero message.
    run(40, 1'b1);

    // Load 1234 and watch it commit at the next frame boundary.
    step(1'b1, 16'h1234, 1'b1);
    run(80, 1'b1);

    // Load while busy is ignored: 1234 occupies the shadow, FFFF must be dropped.
    step(1'b1, 16'h1234, 1'b1);
    step(1'b1, 16'hFFFF, 1'b1);
    run(80, 1'b1);

    // Load on the frame_tick cycle itself: waits one extra frame.
    while ((k % FRAME) != 0) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h5678, 1'b1);
    run(80, 1'b1);

    // Display disabled for 40 cycles, then resumed.
    run(40, 1'b0);
    run(40, 1'b1);

    // Randomized loads and display gating.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 15) == 0, 16'($urandom), $urandom_range(0, 7) != 0);
    end
    run(40, 1'b1);

    // Mid-slot reset with a message pending: it must be discarded.
    while ((k % SCAN_DIV) != 5) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'hABCD, 1'b1);
    run(3, 1'b1);
    do_reset();
    run(80, 1'b1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
